// File: rtl/tr_pkg.sv
// Shared types and helpers for the ADC-error-to-step-command block.
// The optional per-command rate limit is enabled with the RATE_LIMIT_EN macro.
package tr_pkg;

    localparam int unsigned WIDTH_IN_DEF   = 12;
    localparam int unsigned WIDTH_WORK_DEF = 16;
    localparam int unsigned AVG_LOG2_DEF   = 2;
    localparam int unsigned GAIN_SHIFT_DEF = 2;
    localparam int unsigned MAX_DN_DEF     = 64;

    localparam logic [WIDTH_WORK_DEF-1:0] N_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        CALC,
        CMD,
        RUN
    } state_e;

    // Left shift that clamps to lim (an all-ones mask) instead of wrapping.
    function automatic logic [63:0] sat_shl(
        input logic [63:0] val,
        input int unsigned shift,
        input logic [63:0] lim = 64'(N_MAX)
    );
        logic [63:0] res;
        if (val > (lim >> shift)) begin
            res = lim;
        end else begin
            res = val << shift;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_avg.sv
// Accumulates 2^AVG_LOG2 ADC samples; clr restarts the block, en accepts a sample.
// done flags the sample that completes the block (same cycle as en).
module sample_avg #(
    parameter int unsigned WIDTH_IN = 12,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [WIDTH_IN-1:0] data,
    output logic [WIDTH_IN-1:0] avg,
    output logic                done
);

    localparam int unsigned SUM_W = WIDTH_IN + AVG_LOG2;

    logic [SUM_W-1:0]    sum_q, sum_d, sum_base;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d, cnt_base;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        sum_base = clr ? '0 : sum_q;
        cnt_base = clr ? '0 : cnt_q;
        sum_d    = sum_base;
        cnt_d    = cnt_base;
        if (en) begin
            sum_d = sum_base + SUM_W'(data);
            cnt_d = cnt_base + AVG_LOG2'(1);
        end
    end

    assign done = en && (cnt_base == '1);
    assign avg  = sum_q[SUM_W-1:AVG_LOG2];

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_err_to_steps.sv
// Averages ADC samples, compares against x0 +/- dx and issues one step command at a time.
// Define RATE_LIMIT_EN to cap the growth of N between same-direction commands.
module adc_err_to_steps
    import tr_pkg::*;
#(
    parameter int unsigned WIDTH_IN   = WIDTH_IN_DEF,
    parameter int unsigned WIDTH_WORK = WIDTH_WORK_DEF,
    parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
    parameter int unsigned GAIN_SHIFT = GAIN_SHIFT_DEF
`ifdef RATE_LIMIT_EN
    , parameter int unsigned MAX_DN   = MAX_DN_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_IN-1:0]   adc_data,
    input  logic                  adc_valid,
    input  logic [WIDTH_IN-1:0]   x0,
    input  logic [WIDTH_IN-1:0]   dx,
    input  logic                  step_done,
    output logic [WIDTH_WORK-1:0] N,
    output logic                  dir,
    output logic                  data_valid,
    output logic                  drv_SM,
    output logic                  ovr
);

    localparam logic [WIDTH_WORK-1:0] N_ALL = '1;

    state_e                state_q, state_d;
    logic [WIDTH_IN-1:0]   excess_q, excess_d;
    logic                  cdir_q, cdir_d;
    logic [WIDTH_WORK-1:0] n_q, n_d;
    logic                  dir_q, dir_d;
    logic                  dv_q, dv_d;
    logic                  drv_q, drv_d;
    logic                  ovr_q, ovr_d;

    logic                  acc_clr, acc_en, acc_done;
    logic [WIDTH_IN-1:0]   avg;
    logic signed [WIDTH_IN:0] err;
    logic [WIDTH_IN-1:0]   mag;
    logic [WIDTH_WORK-1:0] n_calc, n_cmd;
    logic                  accepting;

    sample_avg #(
        .WIDTH_IN (WIDTH_IN),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk   (clk),
        .rst_n (rst),
        .clr   (acc_clr),
        .en    (acc_en),
        .data  (adc_data),
        .avg   (avg),
        .done  (acc_done)
    );

    assign err = $signed({1'b0, avg}) - $signed({1'b0, x0});
    assign mag = err[WIDTH_IN] ? WIDTH_IN'(-err) : WIDTH_IN'(err);

    // Excess is captured in CALC, so the gain shift sees a stable operand in CMD.
    assign n_calc = WIDTH_WORK'(sat_shl(64'(excess_q), GAIN_SHIFT, 64'(N_ALL)));

`ifdef RATE_LIMIT_EN
    logic [WIDTH_WORK-1:0] n_prev_q, n_prev_d, rl_base, rl_limit;
    logic [WIDTH_WORK:0]   rl_sum;

    // A direction flip restarts the ramp from zero.
    assign rl_base  = (cdir_q != dir_q) ? '0 : n_prev_q;
    assign rl_sum   = {1'b0, rl_base} + (WIDTH_WORK+1)'(MAX_DN);
    assign rl_limit = rl_sum[WIDTH_WORK] ? N_ALL : rl_sum[WIDTH_WORK-1:0];
    assign n_cmd    = (n_calc < rl_limit) ? n_calc : rl_limit;
    assign n_prev_d = (state_q == CMD) ? n_cmd : n_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_prev_q <= '0;
        end else begin
            n_prev_q <= n_prev_d;
        end
    end
`else
    assign n_cmd = n_calc;
`endif

    assign accepting = (state_q == IDLE) || (state_q == ACCUM);

    always_comb begin
        state_d  = state_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        excess_d = excess_q;
        cdir_d   = cdir_q;
        n_d      = n_q;
        dir_d    = dir_q;
        dv_d     = 1'b0;
        drv_d    = drv_q;
        ovr_d    = ovr_q | (adc_valid & ~accepting);

        unique case (state_q)
            IDLE: begin
                acc_clr = 1'b1;
                acc_en  = adc_valid;
                state_d = acc_done ? CALC : ACCUM;
            end
            ACCUM: begin
                acc_en = adc_valid;
                if (acc_done) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                excess_d = mag - dx;
                cdir_d   = (avg > x0);
                state_d  = (mag <= dx) ? IDLE : CMD;
            end
            CMD: begin
                n_d     = n_cmd;
                dir_d   = cdir_q;
                dv_d    = 1'b1;
                drv_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (step_done) begin
                    drv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            excess_q <= '0;
            cdir_q   <= 1'b0;
            n_q      <= '0;
            dir_q    <= 1'b0;
            dv_q     <= 1'b0;
            drv_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            excess_q <= excess_d;
            cdir_q   <= cdir_d;
            n_q      <= n_d;
            dir_q    <= dir_d;
            dv_q     <= dv_d;
            drv_q    <= drv_d;
            ovr_q    <= ovr_d;
        end
    end

    assign N          = n_q;
    assign dir        = dir_q;
    assign data_valid = dv_q;
    assign drv_SM     = drv_q;
    assign ovr        = ovr_q;

endmodule

// File: doc/adc_err_to_steps.md
Name: adc_err_to_steps

Overview:
- Upstream command stage for TR_pulse.
- Averages ADC position samples and compares the mean against setpoint x0 with deadband dx.
- Converts the excess error into a step count N and direction, and issues a one-cycle data_valid strobe plus drv_SM enable to the pulse generator.
- Holds the command until the pulse generator reports completion, so at most one move is outstanding.

Parameters:
- WIDTH_IN, 12, width of adc_data, x0, dx
- WIDTH_WORK, 16, width of N
- AVG_LOG2, 2, log2 of samples averaged per command (1..4)
- GAIN_SHIFT, 2, left shift applied to the excess error to form N
- MAX_DN, 64, max increase of N between commands (RATE_LIMIT_EN only)

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous reset, active-low
- adc_data  in  WIDTH_IN  unsigned ADC sample
- adc_valid  in  1  one-cycle strobe, adc_data valid
- x0  in  WIDTH_IN  unsigned position setpoint, sampled in CALC
- dx  in  WIDTH_IN  unsigned deadband, sampled in CALC
- step_done  in  1  one-cycle strobe from the pulse stage, move finished
- N  out  WIDTH_WORK  step count, registered, stable while drv_SM=1
- dir  out  1  1 = avg above x0, 0 = below
- data_valid  out  1  one-cycle strobe, N/dir updated
- drv_SM  out  1  motor enable, high from CMD until step_done
- ovr  out  1  sticky: a sample arrived while not accepting

Behaviour:
- Reset (rst=0, async): state=IDLE, sum=0, sample count=0; N=0, dir=0, data_valid=0, drv_SM=0, ovr=0. Reset mid-move drops drv_SM immediately.
- States and transitions:
  - IDLE: clears sum and count, then enters ACCUM. This is a 1-cycle pass-through; an adc_valid arriving in IDLE is accepted as the first sample.
  - ACCUM: on each adc_valid, sum += adc_data and count++. When count reaches 2^AVG_LOG2 (inclusive of the current sample), go to CALC on the next edge.
  - CALC (1 cycle):
    - avg = sum >> AVG_LOG2.
    - err = avg - x0, signed WIDTH_IN+1 bits; mag = |err|.
    - If mag <= dx, return to IDLE with no strobe and N/dir unchanged.
    - Otherwise go to CMD.
  - CMD (1 cycle):
    - N <= sat((mag - dx) << GAIN_SHIFT), saturating to 2^WIDTH_WORK - 1.
    - dir <= (avg > x0).
    - data_valid <= 1 for this cycle only; drv_SM <= 1. Go to RUN.
  - RUN: hold N, dir and drv_SM=1. On step_done: drv_SM <= 0, go to IDLE.
- step_done outside RUN is ignored.
- Latency: final sample accepted at edge t gives CALC at t+1; data_valid/N/dir/drv_SM become visible after edge t+2.
- adc_valid during CALC/CMD/RUN: the sample is discarded and ovr is set. ovr clears only on reset.
- Simultaneous step_done and adc_valid in RUN: leave RUN; the sample is discarded and ovr is set.
- Arithmetic: sum width WIDTH_IN+AVG_LOG2 (no overflow possible). Shift performed in WIDTH_WORK+GAIN_SHIFT bits before saturation.

Optional Feature:
- Macro: RATE_LIMIT_EN.
- Defined: a register N_prev (reset 0) tracks the last issued N.
  - In CMD, N = min(computed, N_prev + MAX_DN), with the sum saturated to 2^WIDTH_WORK - 1.
  - Decreases are unlimited.
  - A direction change resets the limit base to 0, so N <= MAX_DN.
- Undefined: N = computed value; no N_prev register.

Decomposition:
- Package tr_pkg:
  - state enum (IDLE, ACCUM, CALC, CMD, RUN)
  - N_MAX constant (all-ones WIDTH_WORK)
  - saturating-shift function
- Sub-module sample_avg: accumulator and counter with clear/enable, producing avg and done. The FSM stays in the top level.

Test Plan:
- Defaults; x0=900, dx=20; four samples of 1000 -> N=320, dir=1, one data_valid pulse 2 cycles after the 4th strobe; drv_SM=1 until step_done, then 0.
- Samples 890,895,905,910 (avg 900), x0=900, dx=20 -> no data_valid, drv_SM stays 0, N unchanged, returns to IDLE.
- Samples 0 x4, x0=4095, dx=0 -> err=-4095, dir=0, N=16380; with GAIN_SHIFT=6 -> N=65535 (saturated).
- adc_valid during RUN, and together with step_done -> sample discarded, ovr=1 and stays 1; the next command averages only new samples.
- rst=0 asserted in RUN -> drv_SM, data_valid, N, ovr are 0 asynchronously; after release, four samples are needed before the next command.
- RATE_LIMIT_EN, MAX_DN=64: first command computed 320 -> N=64; second same-dir computed 320 -> N=128; a dir flip -> N <= 64.
